mem_arbiter: RTL and testbench

//  Shares one main-memory port between the instruction cache and the data cache.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter shared by the instruction cache and the data cache.
// One block transfer is in flight at a time. When both caches ask at once, the
// side that was not granted last goes first. Read blocks are returned through
// registered outputs, and each cache is stalled through its own busywait.
module mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  // instruction cache (read only)
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  // data cache
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  // main memory
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_ACC  = 3'd1,
    I_ACC  = 3'd2,
    D_DONE = 3'd3,
    I_DONE = 3'd4
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  state_e              state_q;
  grant_e              last_grant_q;
  logic                issued_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic [DATA_W-1:0]   mem_writedata_q;
  logic [DATA_W-1:0]   i_readdata_q;
  logic [DATA_W-1:0]   d_readdata_q;

  logic d_req;
  logic i_req;
  logic pick_d;

  assign d_req = D_READ | D_WRITE;
  assign i_req = I_READ;

  // D wins when it is alone, or when both ask and I was served last.
  assign pick_d = d_req && (!i_req || (last_grant_q == GRANT_I));

  // Stall is combinational so it rises in the same cycle as the request and
  // drops only for the single DONE cycle of the requester's own transfer.
  assign I_BUSYWAIT = i_req && (state_q != I_DONE);
  assign D_BUSYWAIT = d_req && (state_q != D_DONE);

  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_address_q;
  assign MEM_WRITEDATA = mem_writedata_q;
  assign I_READDATA    = i_readdata_q;
  assign D_READDATA    = d_readdata_q;

  // Arbitration FSM with registered memory strobes and returned read blocks.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      // NOTE: the returned-data registers are plain flops, not a RAM, so they
      // are cleared here and a cache never sees stale data after reset.
      state_q         <= IDLE;
      last_grant_q    <= GRANT_I;
      issued_q        <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      i_readdata_q    <= '0;
      d_readdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere in this block, so every
      // decision below reads the state as it was before this edge.
      unique case (state_q)
        IDLE: begin
          if (pick_d) begin
            state_q       <= D_ACC;
            last_grant_q  <= GRANT_D;
            mem_address_q <= D_ADDRESS;
            // A simultaneous read and write is resolved as a write.
            mem_write_q   <= D_WRITE;
            mem_read_q    <= D_READ & ~D_WRITE;
            if (D_WRITE) begin
              mem_writedata_q <= D_WRITEDATA;
            end
          end else if (i_req) begin
            state_q       <= I_ACC;
            last_grant_q  <= GRANT_I;
            mem_address_q <= I_ADDRESS;
            mem_read_q    <= 1'b1;
            mem_write_q   <= 1'b0;
          end
        end

        D_ACC, I_ACC: begin
          // The first edge only marks the strobe as seen by memory, so a
          // memory busywait that has not risen yet is not taken as done.
          if (!issued_q) begin
            issued_q <= 1'b1;
          end else if (!MEM_BUSYWAIT) begin
            if (mem_read_q) begin
              if (state_q == D_ACC) begin
                d_readdata_q <= MEM_READDATA;
              end else begin
                i_readdata_q <= MEM_READDATA;
              end
            end
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            issued_q    <= 1'b0;
            state_q     <= (state_q == D_ACC) ? D_DONE : I_DONE;
          end
        end

        D_DONE, I_DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter. A behavioural memory holds busywait high
// for five cycles after it sees a strobe, then returns a fixed word per address.
module tb_mem_arbiter;

  logic        CLK;
  logic        RESET;
  logic        I_READ;
  logic [5:0]  I_ADDRESS;
  logic [31:0] I_READDATA;
  logic        I_BUSYWAIT;
  logic        D_READ;
  logic        D_WRITE;
  logic [5:0]  D_ADDRESS;
  logic [31:0] D_WRITEDATA;
  logic [31:0] D_READDATA;
  logic        D_BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .I_READ       (I_READ),
    .I_ADDRESS    (I_ADDRESS),
    .I_READDATA   (I_READDATA),
    .I_BUSYWAIT   (I_BUSYWAIT),
    .D_READ       (D_READ),
    .D_WRITE      (D_WRITE),
    .D_ADDRESS    (D_ADDRESS),
    .D_WRITEDATA  (D_WRITEDATA),
    .D_READDATA   (D_READDATA),
    .D_BUSYWAIT   (D_BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents as seen by reads.
  function automatic logic [31:0] mem_word(input logic [5:0] addr);
    case (addr)
      6'h05:   mem_word = 32'hA1B2C3D4;
      6'h10:   mem_word = 32'h11111111;
      6'h20:   mem_word = 32'h22222222;
      6'h13:   mem_word = 32'h33333333;
      6'h11:   mem_word = 32'h44444444;
      6'h21:   mem_word = 32'h55555555;
      6'h12:   mem_word = 32'h66666666;
      default: mem_word = {26'h0, addr} ^ 32'h5A5A5A5A;
    endcase
  endfunction

  // Behavioural memory: busy for five cycles after a strobe, abandoned on reset.
  logic       mem_busy;
  int         mem_cnt;
  logic [5:0] last_wr_addr;
  logic [31:0] last_wr_data;
  assign MEM_BUSYWAIT = mem_busy;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_busy     = 1'b0;
      mem_cnt      = 0;
      MEM_READDATA = 32'h0;
    end else begin
      #1;
      if (mem_busy) begin
        mem_cnt = mem_cnt - 1;
        if (mem_cnt == 0) begin
          mem_busy = 1'b0;
          if (MEM_READ)  MEM_READDATA = mem_word(MEM_ADDRESS);
          if (MEM_WRITE) begin
            last_wr_addr = MEM_ADDRESS;
            last_wr_data = MEM_WRITEDATA;
          end
        end
      end else if (MEM_READ || MEM_WRITE) begin
        mem_busy = 1'b1;
        mem_cnt  = 5;
      end
    end
  end

  // Grant monitor: logs the memory address at each rising strobe.
  logic       mon_en = 1'b0;
  logic       mon_prev;
  logic [5:0] grants[$];
  always @(negedge CLK) begin
    if (!mon_en) begin
      grants.delete();
      mon_prev = 1'b0;
    end else begin
      if ((MEM_READ || MEM_WRITE) && !mon_prev) grants.push_back(MEM_ADDRESS);
      mon_prev = MEM_READ || MEM_WRITE;
    end
  end

  task automatic clear_inputs();
    I_READ = 1'b0; I_ADDRESS = 6'h0;
    D_READ = 1'b0; D_WRITE = 1'b0; D_ADDRESS = 6'h0; D_WRITEDATA = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    clear_inputs();
    RESET = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // Counts cycles the chosen requester stays stalled, starting at the current
  // sample point; snapshots the memory port on the first strobed cycle.
  task automatic run_until_ready(input bit is_d, output int cycles,
                                 output logic snap_rd, output logic snap_wr,
                                 output logic [5:0] snap_addr,
                                 output logic [31:0] snap_wd,
                                 output bit other_busy);
    bit seen;
    seen = 1'b0; cycles = 0; other_busy = 1'b1;
    snap_rd = 1'b0; snap_wr = 1'b0; snap_addr = 6'h0; snap_wd = 32'h0;
    while (((is_d ? D_BUSYWAIT : I_BUSYWAIT) === 1'b1) && cycles < 40) begin
      cycles++;
      if (!seen && (MEM_READ || MEM_WRITE)) begin
        seen = 1'b1;
        snap_rd = MEM_READ; snap_wr = MEM_WRITE;
        snap_addr = MEM_ADDRESS; snap_wd = MEM_WRITEDATA;
      end
      if ((is_d ? I_BUSYWAIT : D_BUSYWAIT) !== 1'b1) other_busy = 1'b0;
      @(negedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    logic [108:0] outs;
    @(negedge CLK); #1;
    outs = {MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, I_READDATA,
            D_READDATA, I_BUSYWAIT, D_BUSYWAIT};
    n_checks++;
    if (outs !== '0) $display("FAIL reset_held: outputs=%h expected 0", outs);
    else n_pass++;
    RESET = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK); #1;
      outs = {MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA, I_READDATA,
              D_READDATA, I_BUSYWAIT, D_BUSYWAIT};
      n_checks++;
      if (outs !== '0) $display("FAIL idle_cycle%0d: outputs=%h expected 0", c, outs);
      else n_pass++;
    end
  endtask

  task automatic test_i_read();
    int cyc; logic rd, wr; logic [5:0] a; logic [31:0] wd; bit ob;
    @(negedge CLK);
    I_ADDRESS = 6'h05; I_READ = 1'b1;
    #1;
    run_until_ready(1'b0, cyc, rd, wr, a, wd, ob);
    n_checks++;
    if (cyc !== 7) $display("FAIL i_busy_cycles: got %0d expected 7", cyc);
    else n_pass++;
    n_checks++;
    if ({rd, wr, a} !== {1'b1, 1'b0, 6'h05})
      $display("FAIL i_strobe: rd=%b wr=%b addr=%h expected 1 0 05", rd, wr, a);
    else n_pass++;
    n_checks++;
    if (I_READDATA !== 32'hA1B2C3D4)
      $display("FAIL i_readdata: got %h expected a1b2c3d4", I_READDATA);
    else n_pass++;
    n_checks++;
    if (MEM_READ !== 1'b0) $display("FAIL i_strobe_drop: MEM_READ=%b expected 0", MEM_READ);
    else n_pass++;
    I_READ = 1'b0;
    @(negedge CLK); #1;
    n_checks++;
    if ({I_BUSYWAIT, D_READDATA} !== {1'b0, 32'h0})
      $display("FAIL i_after: busy=%b d_readdata=%h expected 0 0", I_BUSYWAIT, D_READDATA);
    else n_pass++;
  endtask

  task automatic test_d_write();
    int cyc; logic rd, wr; logic [5:0] a; logic [31:0] wd; bit ob;
    @(negedge CLK);
    D_ADDRESS = 6'h3F; D_WRITEDATA = 32'hDEADBEEF; D_WRITE = 1'b1;
    #1;
    run_until_ready(1'b1, cyc, rd, wr, a, wd, ob);
    n_checks++;
    if (cyc !== 7) $display("FAIL d_wr_busy_cycles: got %0d expected 7", cyc);
    else n_pass++;
    n_checks++;
    if ({rd, wr, a, wd} !== {1'b0, 1'b1, 6'h3F, 32'hDEADBEEF})
      $display("FAIL d_wr_port: rd=%b wr=%b addr=%h data=%h expected 0 1 3f deadbeef",
               rd, wr, a, wd);
    else n_pass++;
    n_checks++;
    if ({last_wr_addr, last_wr_data} !== {6'h3F, 32'hDEADBEEF})
      $display("FAIL d_wr_mem: addr=%h data=%h expected 3f deadbeef", last_wr_addr, last_wr_data);
    else n_pass++;
    n_checks++;
    if (D_READDATA !== 32'h0) $display("FAIL d_wr_readdata: got %h expected 0", D_READDATA);
    else n_pass++;
    D_WRITE = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_read_write_clash();
    int cyc; logic rd, wr; logic [5:0] a; logic [31:0] wd; bit ob;
    @(negedge CLK);
    D_ADDRESS = 6'h2A; D_WRITEDATA = 32'h12345678; D_READ = 1'b1; D_WRITE = 1'b1;
    #1;
    run_until_ready(1'b1, cyc, rd, wr, a, wd, ob);
    n_checks++;
    if ({rd, wr, a, wd} !== {1'b0, 1'b1, 6'h2A, 32'h12345678})
      $display("FAIL clash_as_write: rd=%b wr=%b addr=%h data=%h expected 0 1 2a 12345678",
               rd, wr, a, wd);
    else n_pass++;
    n_checks++;
    if (D_READDATA !== 32'h0) $display("FAIL clash_readdata: got %h expected 0", D_READDATA);
    else n_pass++;
    D_READ = 1'b0; D_WRITE = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_simultaneous();
    int cyc; logic rd, wr; logic [5:0] a; logic [31:0] wd; bit ob;
    do_reset();
    @(negedge CLK);
    D_ADDRESS = 6'h10; D_READ = 1'b1;
    I_ADDRESS = 6'h20; I_READ = 1'b1;
    #1;
    run_until_ready(1'b1, cyc, rd, wr, a, wd, ob);
    n_checks++;
    if ({cyc, a} !== {32'd7, 6'h10})
      $display("FAIL sim_d_first: cycles=%0d addr=%h expected 7 10", cyc, a);
    else n_pass++;
    n_checks++;
    if ({ob, I_BUSYWAIT} !== 2'b11)
      $display("FAIL sim_i_stalled: during=%b at_done=%b expected 1 1", ob, I_BUSYWAIT);
    else n_pass++;
    n_checks++;
    if (D_READDATA !== 32'h11111111) $display("FAIL sim_d_data: got %h expected 11111111", D_READDATA);
    else n_pass++;
    D_READ = 1'b0;
    run_until_ready(1'b0, cyc, rd, wr, a, wd, ob);
    n_checks++;
    if ({cyc, a} !== {32'd8, 6'h20})
      $display("FAIL sim_i_second: cycles=%0d addr=%h expected 8 20", cyc, a);
    else n_pass++;
    n_checks++;
    if ({I_READDATA, D_READDATA} !== {32'h22222222, 32'h11111111})
      $display("FAIL sim_data: i=%h d=%h expected 22222222 11111111", I_READDATA, D_READDATA);
    else n_pass++;
    I_READ = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int cyc; int d_done; int i_done;
    logic [31:0] d_got0, d_got1, i_got;
    d_got0 = 32'h0; d_got1 = 32'h0; i_got = 32'h0;
    mon_en = 1'b1;
    @(negedge CLK);
    D_ADDRESS = 6'h11; D_READ = 1'b1;
    I_ADDRESS = 6'h21; I_READ = 1'b1;
    cyc = 0; d_done = 0; i_done = 0;
    while (!(d_done == 2 && i_done == 1) && cyc < 100) begin
      @(negedge CLK); #1;
      cyc++;
      if (D_READ && !D_BUSYWAIT) begin
        d_done++;
        if (d_done == 1) begin
          d_got0 = D_READDATA;
          D_ADDRESS = 6'h12;
        end else begin
          d_got1 = D_READDATA;
          D_READ = 1'b0;
        end
      end
      if (I_READ && !I_BUSYWAIT) begin
        i_got = I_READDATA;
        i_done++;
        I_READ = 1'b0;
      end
    end
    n_checks++;
    if ({d_done, i_done} !== {32'd2, 32'd1})
      $display("FAIL b2b_complete: d=%0d i=%0d expected 2 1", d_done, i_done);
    else n_pass++;
    n_checks++;
    if (grants.size() != 3)
      $display("FAIL b2b_grant_count: got %0d expected 3", grants.size());
    else begin
      if ({grants[0], grants[1], grants[2]} !== {6'h11, 6'h21, 6'h12})
        $display("FAIL b2b_order: got %h %h %h expected 11 21 12", grants[0], grants[1], grants[2]);
      else n_pass++;
    end
    n_checks++;
    if ({d_got0, i_got, d_got1} !== {32'h44444444, 32'h55555555, 32'h66666666})
      $display("FAIL b2b_data: d0=%h i=%h d1=%h expected 44444444 55555555 66666666",
               d_got0, i_got, d_got1);
    else n_pass++;
    mon_en = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_transfer();
    int cyc; logic rd, wr; logic [5:0] a; logic [31:0] wd; bit ob;
    @(negedge CLK);
    D_ADDRESS = 6'h13; D_READ = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    n_checks++;
    if (MEM_READ !== 1'b1) $display("FAIL rst_mid_pre: MEM_READ=%b expected 1", MEM_READ);
    else n_pass++;
    RESET = 1'b0;
    #1;
    n_checks++;
    if ({MEM_READ, MEM_WRITE, MEM_ADDRESS, D_READDATA, D_BUSYWAIT} !== {1'b0, 1'b0, 6'h0, 32'h0, 1'b1})
      $display("FAIL rst_mid_async: rd=%b wr=%b addr=%h d=%h busy=%b expected 0 0 00 0 1",
               MEM_READ, MEM_WRITE, MEM_ADDRESS, D_READDATA, D_BUSYWAIT);
    else n_pass++;
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    run_until_ready(1'b1, cyc, rd, wr, a, wd, ob);
    n_checks++;
    if ({cyc, rd, a} !== {32'd7, 1'b1, 6'h13})
      $display("FAIL rst_mid_regrant: cycles=%0d rd=%b addr=%h expected 7 1 13", cyc, rd, a);
    else n_pass++;
    n_checks++;
    if (D_READDATA !== 32'h33333333) $display("FAIL rst_mid_data: got %h expected 33333333", D_READDATA);
    else n_pass++;
    D_READ = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b0;
    clear_inputs();
    repeat (2) @(negedge CLK);
    test_reset();
    test_i_read();
    test_d_write();
    test_read_write_clash();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
